// File: rtl/pipe_pkg.sv
// pipe_pkg: shared ALU and mul/div encodings for the execute stage
package pipe_pkg;
  localparam int ALU_OP_WIDTH = 4;
  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;
  typedef enum logic [1:0] {MD_MUL, MD_MULH, MD_DIV, MD_REM} muldiv_op_e;
  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} muldiv_state_e;
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative signed multiply/divide, one bit per cycle on operand magnitudes
module muldiv_iter #(
  parameter int W = 32
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic         hold_i,
  input  logic [1:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] result_o
);
  import pipe_pkg::*;
  localparam int CW = $clog2(W);
  muldiv_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, mplier_q, mplier_d, quo_q, quo_d;
  logic [2*W-1:0] acc_q, acc_d, mcand_q, mcand_d, prod;
  logic [W:0] rem_q, rem_d, shifted;
  logic [W+1:0] trial;
  logic [W-1:0] quo_s, rem_s;
  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    return x[W-1] ? -x : x;
  endfunction
  assign shifted = {rem_q[W-1:0], quo_q[W-1]};
  assign trial = {1'b0, shifted} - {2'b0, mag(b_q)};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    rem_d = rem_q;
    quo_d = quo_q;
    if (state_q == MD_IDLE) begin
      if (start_i) begin
        state_d = MD_RUN;
        cnt_d = '0;
        op_d = op_i;
        a_d = a_i;
        b_d = b_i;
        acc_d = '0;
        mcand_d = {{W{1'b0}}, mag(a_i)};
        mplier_d = mag(b_i);
        rem_d = '0;
        quo_d = mag(a_i);
      end
    end else if (abort_i) begin
      state_d = MD_IDLE;
    end else if (state_q == MD_RUN) begin
      acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      rem_d = trial[W+1] ? shifted : trial[W:0];
      quo_d = {quo_q[W-2:0], ~trial[W+1]};
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == CW'(W - 1) ? MD_DONE : MD_RUN;
    end else if (!hold_i) begin
      state_d = MD_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end
  assign prod = (a_q[W-1] ^ b_q[W-1]) ? -acc_q : acc_q;
  assign quo_s = (a_q[W-1] ^ b_q[W-1]) ? -quo_q : quo_q;
  assign rem_s = a_q[W-1] ? -rem_q[W-1:0] : rem_q[W-1:0];
  assign result_o = op_q == MD_MUL  ? prod[W-1:0] :
                    op_q == MD_MULH ? prod[2*W-1:W] :
                    b_q == '0       ? (op_q == MD_DIV ? '1 : a_q) :
                    op_q == MD_DIV  ? quo_s : rem_s;
  assign busy_o = state_q != MD_DONE;
  assign done_o = state_q == MD_DONE;
endmodule

// File: rtl/execute_pipe_stage.sv
// execute_pipe_stage: forwarding, ALU, E/M register; iterative mul/div when `define MULDIV_EN
module execute_pipe_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int CONTROL_WIDTH = 4,
  parameter int FWD_SRCS      = 2,
  parameter int REG_ADDR_W    = 5
)(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             validE_i,
  input  logic [DATA_WIDTH-1:0]            RD1E_i,
  input  logic [DATA_WIDTH-1:0]            RD2E_i,
  input  logic [DATA_WIDTH-1:0]            ExtImmE_i,
  input  logic [DATA_WIDTH-1:0]            PCE_i,
  input  logic [DATA_WIDTH-1:0]            PCPlus4E_i,
  input  logic [REG_ADDR_W-1:0]            RdE_i,
  input  logic [CONTROL_WIDTH-1:0]         ALUControlE_i,
  input  logic                             ALUSrcE_i,
  input  logic                             MulDivE_i,
  input  logic [1:0]                       MulDivOpE_i,
  input  logic [$clog2(FWD_SRCS+1)-1:0]    FwdAE_i,
  input  logic [$clog2(FWD_SRCS+1)-1:0]    FwdBE_i,
  input  logic [FWD_SRCS*DATA_WIDTH-1:0]   FwdData_i,
  input  logic                             stallM_i,
  input  logic                             flushE_i,
  output logic                             busyE_o,
  output logic                             ZeroE_o,
  output logic [DATA_WIDTH-1:0]            PCTargetE_o,
  output logic                             validM_o,
  output logic [DATA_WIDTH-1:0]            ALUResultM_o,
  output logic [DATA_WIDTH-1:0]            WriteDataM_o,
  output logic [REG_ADDR_W-1:0]            RdM_o,
  output logic [DATA_WIDTH-1:0]            PCPlus4M_o
);
  import pipe_pkg::*;
  localparam int SW = $clog2(DATA_WIDTH);
  logic [DATA_WIDTH-1:0] src_a, fwd_b, src_b, alu_res, md_res;
  logic [SW-1:0] shamt;
  logic md_sel, busy;
  logic valid_m_q, valid_m_d;
  logic [DATA_WIDTH-1:0] alu_m_q, alu_m_d, wd_m_q, wd_m_d, pc4_m_q, pc4_m_d;
  logic [REG_ADDR_W-1:0] rd_m_q, rd_m_d;
  always_comb begin
    src_a = RD1E_i;
    fwd_b = RD2E_i;
    for (int k = 0; k < FWD_SRCS; k++) begin
      src_a = int'(FwdAE_i) == k + 1 ? FwdData_i[k*DATA_WIDTH +: DATA_WIDTH] : src_a;
      fwd_b = int'(FwdBE_i) == k + 1 ? FwdData_i[k*DATA_WIDTH +: DATA_WIDTH] : fwd_b;
    end
  end
  assign src_b = ALUSrcE_i ? ExtImmE_i : fwd_b;
  assign shamt = src_b[SW-1:0];
  always_comb begin
    case (ALUControlE_i)
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SUB:  alu_res = src_a - src_b;
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_SLT:  alu_res = DATA_WIDTH'($signed(src_a) < $signed(src_b));
      ALU_SLL:  alu_res = src_a << shamt;
      ALU_SRL:  alu_res = src_a >> shamt;
      ALU_SRA:  alu_res = DATA_WIDTH'($signed(src_a) >>> shamt);
      ALU_SLTU: alu_res = DATA_WIDTH'(src_a < src_b);
      default:  alu_res = '0;
    endcase
  end
  assign ZeroE_o = alu_res == '0;
  assign PCTargetE_o = PCE_i + ExtImmE_i;
`ifdef MULDIV_EN
  logic md_req, md_busy, unused_md_done;
  assign md_req = validE_i & MulDivE_i & ~flushE_i;
  assign busy = md_req & md_busy;
  assign md_sel = MulDivE_i;
  muldiv_iter #(.W(DATA_WIDTH)) u_muldiv (
    .clk(clk),
    .rst(rst),
    .start_i(md_req),
    .abort_i(flushE_i),
    .hold_i(stallM_i),
    .op_i(MulDivOpE_i),
    .a_i(src_a),
    .b_i(fwd_b),
    .busy_o(md_busy),
    .done_o(unused_md_done),
    .result_o(md_res)
  );
`else
  logic unused_md;
  assign unused_md = ^{MulDivE_i, MulDivOpE_i};
  assign busy = 1'b0;
  assign md_sel = 1'b0;
  assign md_res = '0;
`endif
  assign busyE_o = busy;
  always_comb begin
    valid_m_d = validE_i;
    alu_m_d = md_sel ? md_res : alu_res;
    wd_m_d = fwd_b;
    rd_m_d = RdE_i;
    pc4_m_d = PCPlus4E_i;
    if (stallM_i) begin
      valid_m_d = valid_m_q;
      alu_m_d = alu_m_q;
      wd_m_d = wd_m_q;
      rd_m_d = rd_m_q;
      pc4_m_d = pc4_m_q;
    end else if (flushE_i || busy) begin
      valid_m_d = 1'b0;
      alu_m_d = '0;
      wd_m_d = '0;
      rd_m_d = '0;
      pc4_m_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_m_q <= 1'b0;
      alu_m_q <= '0;
      wd_m_q <= '0;
      rd_m_q <= '0;
      pc4_m_q <= '0;
    end else begin
      valid_m_q <= valid_m_d;
      alu_m_q <= alu_m_d;
      wd_m_q <= wd_m_d;
      rd_m_q <= rd_m_d;
      pc4_m_q <= pc4_m_d;
    end
  end
  assign validM_o = valid_m_q;
  assign ALUResultM_o = alu_m_q;
  assign WriteDataM_o = wd_m_q;
  assign RdM_o = rd_m_q;
  assign PCPlus4M_o = pc4_m_q;
endmodule

// File: tb/tb_execute_pipe_stage.sv
// tb_execute_pipe_stage: directed + random scoreboard bench for execute_pipe_stage
module tb_execute_pipe_stage;
  logic clk = 1'b0;
  logic rst, validE_i, ALUSrcE_i, MulDivE_i, stallM_i, flushE_i;
  logic [31:0] RD1E_i, RD2E_i, ExtImmE_i, PCE_i, PCPlus4E_i;
  logic [4:0] RdE_i;
  logic [3:0] ALUControlE_i;
  logic [1:0] MulDivOpE_i, FwdAE_i, FwdBE_i;
  logic [63:0] FwdData_i;
  logic busyE_o, ZeroE_o, validM_o;
  logic [31:0] PCTargetE_o, ALUResultM_o, WriteDataM_o, PCPlus4M_o;
  logic [4:0] RdM_o;
  typedef struct {
    logic [31:0] res;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] pc4;
    int          lat;
    int          busy;
  } exp_t;
  exp_t sb[$];
  exp_t last;
  int checks = 0;
  int passes = 0;
  always #5 clk = ~clk;
  execute_pipe_stage dut (
    .clk(clk), .rst(rst), .validE_i(validE_i), .RD1E_i(RD1E_i), .RD2E_i(RD2E_i),
    .ExtImmE_i(ExtImmE_i), .PCE_i(PCE_i), .PCPlus4E_i(PCPlus4E_i), .RdE_i(RdE_i),
    .ALUControlE_i(ALUControlE_i), .ALUSrcE_i(ALUSrcE_i), .MulDivE_i(MulDivE_i),
    .MulDivOpE_i(MulDivOpE_i), .FwdAE_i(FwdAE_i), .FwdBE_i(FwdBE_i), .FwdData_i(FwdData_i),
    .stallM_i(stallM_i), .flushE_i(flushE_i), .busyE_o(busyE_o), .ZeroE_o(ZeroE_o),
    .PCTargetE_o(PCTargetE_o), .validM_o(validM_o), .ALUResultM_o(ALUResultM_o),
    .WriteDataM_o(WriteDataM_o), .RdM_o(RdM_o), .PCPlus4M_o(PCPlus4M_o)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return {31'b0, $signed(a) < $signed(b)};
      4'd6: return a << b[4:0];
      4'd7: return a >> b[4:0];
      4'd8: return $signed(a) >>> b[4:0];
      4'd9: return {31'b0, a < b};
      default: return 32'd0;
    endcase
  endfunction
  function automatic logic [31:0] md_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    if (op == 2'd0) return p[31:0];
    if (op == 2'd1) return p[63:32];
    if (b == 32'd0) return op == 2'd2 ? 32'hFFFF_FFFF : a;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op == 2'd2 ? a : 32'd0;
    if (op == 2'd2) return $signed(a) / $signed(b);
    return $signed(a) % $signed(b);
  endfunction
  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] r);
    if (s == 2'd1) return FwdData_i[31:0];
    if (s == 2'd2) return FwdData_i[63:32];
    return r;
  endfunction
  task automatic issue(input logic [3:0] ctrl, input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [31:0] imm, input logic src, input logic [1:0] fa,
                       input logic [1:0] fb, input logic md, input logic [1:0] op);
    exp_t e;
    logic [31:0] a, bw, b;
    validE_i = 1'b1;
    ALUControlE_i = ctrl;
    RD1E_i = rd1;
    RD2E_i = rd2;
    ExtImmE_i = imm;
    ALUSrcE_i = src;
    FwdAE_i = fa;
    FwdBE_i = fb;
    MulDivE_i = md;
    MulDivOpE_i = op;
    RdE_i = 5'($urandom);
    PCE_i = $urandom;
    PCPlus4E_i = $urandom;
    a = pick(fa, rd1);
    bw = pick(fb, rd2);
    b = src ? imm : bw;
    e.wd = bw;
    e.rd = RdE_i;
    e.pc4 = PCPlus4E_i;
`ifdef MULDIV_EN
    e.res = md ? md_model(op, a, bw) : alu_model(ctrl, a, b);
    e.lat = md ? 34 : 1;
    e.busy = md ? 33 : 0;
`else
    e.res = alu_model(ctrl, a, b);
    e.lat = 1;
    e.busy = 0;
`endif
    sb.push_back(e);
  endtask
  task automatic collect(input string tag, input bit timing);
    exp_t e;
    int edges, nbusy;
    edges = 0;
    nbusy = 0;
    e = sb.pop_front();
    while (edges < 60) begin
      if (busyE_o) nbusy++;
      @(posedge clk);
      #1;
      edges++;
      if (validM_o) break;
    end
    validE_i = 1'b0;
    last = e;
    chk({tag, ".valid"}, 64'(validM_o), 64'd1);
    if (timing) begin
      chk({tag, ".lat"}, 64'(edges), 64'(e.lat));
      chk({tag, ".busy"}, 64'(nbusy), 64'(e.busy));
    end
    chk({tag, ".res"}, 64'(ALUResultM_o), 64'(e.res));
    chk({tag, ".wd"}, 64'(WriteDataM_o), 64'(e.wd));
    chk({tag, ".rd"}, 64'(RdM_o), 64'(e.rd));
    chk({tag, ".pc4"}, 64'(PCPlus4M_o), 64'(e.pc4));
  endtask
  task automatic chk_m_zero(input string tag);
    chk({tag, ".validM"}, 64'(validM_o), 64'd0);
    chk({tag, ".res"}, 64'(ALUResultM_o), 64'd0);
    chk({tag, ".wd"}, 64'(WriteDataM_o), 64'd0);
    chk({tag, ".rd"}, 64'(RdM_o), 64'd0);
    chk({tag, ".pc4"}, 64'(PCPlus4M_o), 64'd0);
    chk({tag, ".busy"}, 64'(busyE_o), 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    rst = 1'b1;
    validE_i = 1'b0;
    {RD1E_i, RD2E_i, ExtImmE_i, PCE_i, PCPlus4E_i} = '0;
    RdE_i = '0;
    ALUControlE_i = '0;
    {ALUSrcE_i, MulDivE_i, stallM_i, flushE_i} = '0;
    MulDivOpE_i = '0;
    FwdAE_i = '0;
    FwdBE_i = '0;
    FwdData_i = {32'h55, 32'd100};
    repeat (2) @(posedge clk);
    #1;
    chk_m_zero("reset");
    rst = 1'b0;
    issue(4'd0, 32'd5, 32'd9, 32'd7, 1'b1, 2'd1, 2'd0, 1'b0, 2'd0);
    collect("t1_fwd_add", 1'b1);
    chk("t1_lit", 64'(ALUResultM_o), 64'd107);
    issue(4'd1, 32'd50, 32'd1, 32'd0, 1'b0, 2'd0, 2'd2, 1'b0, 2'd0);
    collect("fwd_b_slice1", 1'b1);
    issue(4'd4, 32'h0F0F_0F0F, 32'h1234_5678, 32'd0, 1'b0, 2'd3, 2'd3, 1'b0, 2'd0);
    collect("fwd_out_of_range", 1'b1);
    issue(4'd8, 32'hFFFF_FFF0, 32'd2, 32'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);
    collect("sra", 1'b1);
    chk("sra_lit", 64'(ALUResultM_o), 64'hFFFF_FFFC);
    issue(4'd9, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0);
    collect("sltu", 1'b1);
    chk("sltu_lit", 64'(ALUResultM_o), 64'd1);
    issue(4'd1, 32'd3, 32'd3, 32'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);
    #1;
    chk("zero_set", 64'(ZeroE_o), 64'd1);
    collect("sub_zero", 1'b1);
    issue(4'd0, 32'd1, 32'd0, 32'hFFFF_FFFC, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0);
    PCE_i = 32'h100;
    #1;
    chk("pctarget", 64'(PCTargetE_o), 64'hFC);
    chk("zero_clear", 64'(ZeroE_o), 64'd0);
    collect("add_neg_imm", 1'b1);
    issue(4'd12, 32'd77, 32'd1, 32'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);
    collect("bad_code", 1'b1);
    for (int i = 0; i < 16; i++) begin
      FwdData_i = {$urandom, $urandom};
      issue(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, 1'($urandom),
            2'($urandom), 2'($urandom), 1'b0, 2'd0);
      collect("rand_alu", 1'b1);
    end
    issue(4'd0, 32'd100, 32'hFFFF_FFF9, 32'd0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd2);
    collect("div", 1'b1);
`ifdef MULDIV_EN
    chk("div_lit", 64'(ALUResultM_o), 64'hFFFF_FFF2);
`endif
    issue(4'd0, 32'd100, 32'hFFFF_FFF9, 32'd0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd3);
    collect("rem", 1'b1);
    issue(4'd0, 32'h8000_0000, 32'd2, 32'd0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd1);
    collect("mulh", 1'b1);
    issue(4'd0, 32'd42, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd2);
    collect("div0", 1'b1);
    issue(4'd0, 32'd42, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd3);
    collect("rem0", 1'b1);
    issue(4'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd2);
    collect("div_ovf", 1'b1);
    issue(4'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd3);
    collect("rem_ovf", 1'b1);
    for (int i = 0; i < 4; i++) begin
      FwdData_i = {$urandom, $urandom};
      issue(4'($urandom_range(0, 9)), $urandom, $urandom, $urandom, 1'b0,
            2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), 1'b1, 2'(i));
      collect("rand_md", 1'b1);
    end
    stallM_i = 1'b1;
    issue(4'd0, 32'd100, 32'hFFFF_FFF9, 32'd0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd2);
    n = sb[$].busy + 3;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("stall_hold.valid", 64'(validM_o), 64'd1);
      chk("stall_hold.res", 64'(ALUResultM_o), 64'(last.res));
      chk("stall_hold.rd", 64'(RdM_o), 64'(last.rd));
    end
    chk("stall_busy", 64'(busyE_o), 64'd0);
    stallM_i = 1'b0;
    collect("stall_release", 1'b0);
    issue(4'd0, 32'd123, 32'd5, 32'd0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd2);
    void'(sb.pop_back());
    repeat (11) @(posedge clk);
    #1;
    flushE_i = 1'b1;
    #1;
    chk("flush_busy", 64'(busyE_o), 64'd0);
    @(posedge clk);
    #1;
    chk_m_zero("flush");
    flushE_i = 1'b0;
    validE_i = 1'b0;
    @(posedge clk);
    #1;
    issue(4'd0, 32'd1000, 32'd7, 32'd0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd2);
    collect("after_flush", 1'b1);
    issue(4'd0, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd0);
    void'(sb.pop_back());
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    validE_i = 1'b0;
    @(posedge clk);
    #1;
    chk_m_zero("rst_mid");
    rst = 1'b0;
    issue(4'd0, 32'hFFFF_FFFD, 32'd7, 32'd0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd0);
    collect("after_rst", 1'b1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
